jk_ubus_master: RTL

JK_UBUS_MASTER -- requirements
Module: jk_ubus_master

---
 rtl/jk_ubus_pkg.sv | 15 +
 rtl/jk_ubus_master.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/jk_ubus_pkg.sv
// jk_ubus_pkg: shared FSM states, transfer-size encodings and beat-count helper for the UBUS master.
package jk_ubus_pkg;

    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, RESP} state_e;

    localparam logic [1:0] SZ_1 = 2'b00;
    localparam logic [1:0] SZ_2 = 2'b01;
    localparam logic [1:0] SZ_4 = 2'b10;
    localparam logic [1:0] SZ_8 = 2'b11;

    function automatic logic [3:0] size_nbeats(input logic [1:0] sz);
        return (sz == SZ_1) ? 4'd1 : (sz == SZ_2) ? 4'd2 : (sz == SZ_4) ? 4'd4 : (sz == SZ_8) ? 4'd8 : 4'd0;
    endfunction

endpackage

// File: rtl/jk_ubus_master.sv
// jk_ubus_master: single-command UBUS master moving 1-8 bytes over a split byte data bus.
module jk_ubus_master
    import jk_ubus_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic              cmd_write,
    input  logic [63:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [63:0]       rsp_rdata,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        size,
    output logic              read,
    output logic              write,
    output logic              bip,
    output logic [7:0]        data_out,
    output logic              data_oe,
    input  logic [7:0]        data_in,
    input  logic              wait_state,
    input  logic              error
);

    state_e            state_q;
    logic [2:0]        beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rbuf_q;

    logic              last;
    logic [2:0]        beat_d;
    logic [63:0]       rbuf_d;

    assign last   = {1'b0, beat_q} == size_nbeats(size_q) - 4'd1;
    assign beat_d = beat_q + 3'd1;
    assign rbuf_d = rbuf_q | ({56'd0, data_in} << {beat_q, 3'b000});

    // Every output is a register so reset clears the bus asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rbuf_q    <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            req       <= 1'b0;
            addr      <= '0;
            size      <= '0;
            read      <= 1'b0;
            write     <= 1'b0;
            bip       <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            req       <= 1'b0;
            addr      <= '0;
            size      <= '0;
            read      <= 1'b0;
            write     <= 1'b0;
            bip       <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        state_q <= ARB;
                        addr_q  <= cmd_addr;
                        size_q  <= cmd_size;
                        write_q <= cmd_write;
                        wdata_q <= cmd_wdata;
                        rbuf_q  <= '0;
                        beat_q  <= '0;
                        req     <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ARB: begin
                    if (gnt) begin
                        state_q <= ADDR;
                        addr    <= addr_q;
                        size    <= size_q;
                        read    <= !write_q;
                        write   <= write_q;
                    end else begin
                        req <= 1'b1;
                    end
                end
                ADDR: begin
                    state_q  <= DATA;
                    beat_q   <= '0;
                    bip      <= size_nbeats(size_q) != 4'd1;
                    data_oe  <= write_q;
                    data_out <= write_q ? wdata_q[7:0] : 8'd0;
                end
                DATA: begin
                    if (error) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= write_q ? 64'd0 : rbuf_q;
                    end else if (wait_state) begin
                        bip      <= bip;
                        data_oe  <= data_oe;
                        data_out <= data_out;
                    end else if (last) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= write_q ? 64'd0 : rbuf_d;
                        rbuf_q    <= write_q ? rbuf_q : rbuf_d;
                    end else begin
                        beat_q   <= beat_d;
                        rbuf_q   <= write_q ? rbuf_q : rbuf_d;
                        bip      <= {1'b0, beat_d} != size_nbeats(size_q) - 4'd1;
                        data_oe  <= write_q;
                        data_out <= write_q ? wdata_q[{beat_d, 3'b000} +: 8] : 8'd0;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
